// File: rtl/s_link_sched.sv
// s_link_sched: round scheduler for a shared two-unit serial link.
// Alternates the transmitter per round, with turnaround gaps, a watchdog and abort.
module s_link_sched #(
    parameter int N_ROUNDS = 4,
    parameter int FIRST_TX = 0,
    parameter int TURN_GAP = 4,
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       S_done_0,
    input  logic       S_done_1,
    output logic       updown_0,
    output logic       updown_1,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] round,
    output logic       tx_sel
);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        XFER,
        TURN,
        FIN
    } state_t;

    localparam int GW = $clog2(TURN_GAP + 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'(TURN_GAP - 1);
    localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [7:0]      R_LAST   = 8'(N_ROUNDS - 1);
    localparam logic            TX0      = 1'(FIRST_TX);

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [7:0]      round_q, round_d;
    logic            tx_sel_q, tx_sel_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            updown_0_q, updown_0_d;
    logic            updown_1_q, updown_1_d;
    logic            sd0_prev_q, sd0_prev_d;
    logic            sd1_prev_q, sd1_prev_d;

    logic rx_now;
    logic rx_prev;
    logic rx_edge;

    // Receiver is the unit not transmitting; completion is a fresh rising edge.
    always_comb begin
        rx_now  = tx_sel_q ? S_done_0 : S_done_1;
        rx_prev = tx_sel_q ? sd0_prev_q : sd1_prev_q;
        rx_edge = rx_now & ~rx_prev;
    end

    // Next-state, counters and registered output values.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        wd_d       = wd_q;
        round_d    = round_q;
        tx_sel_d   = tx_sel_q;
        err_d      = err_q;
        sd0_prev_d = S_done_0;
        sd1_prev_d = S_done_1;

        if (abort) begin
            state_d = IDLE;
            gap_d   = '0;
            wd_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = GAP;
                        gap_d    = '0;
                        round_d  = '0;
                        tx_sel_d = TX0;
                        err_d    = 1'b0;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = XFER;
                        gap_d   = '0;
                        wd_d    = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                XFER: begin
                    if (rx_edge) begin
                        state_d = (round_q == R_LAST) ? FIN : TURN;
                        gap_d   = '0;
                        wd_d    = '0;
                    end else if (wd_q == WD_LAST) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        wd_d    = '0;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                    end
                end
                TURN: begin
                    if (gap_q == GAP_LAST) begin
                        state_d  = XFER;
                        gap_d    = '0;
                        wd_d     = '0;
                        round_d  = round_q + 8'd1;
                        tx_sel_d = ~tx_sel_q;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        updown_0_d = (state_d == XFER) && !tx_sel_d;
        updown_1_d = (state_d == XFER) && tx_sel_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            wd_q       <= '0;
            round_q    <= '0;
            tx_sel_q   <= TX0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            updown_0_q <= 1'b0;
            updown_1_q <= 1'b0;
            sd0_prev_q <= 1'b0;
            sd1_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            wd_q       <= wd_d;
            round_q    <= round_d;
            tx_sel_q   <= tx_sel_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            updown_0_q <= updown_0_d;
            updown_1_q <= updown_1_d;
            sd0_prev_q <= sd0_prev_d;
            sd1_prev_q <= sd1_prev_d;
        end
    end

    assign updown_0 = updown_0_q;
    assign updown_1 = updown_1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign round    = round_q;
    assign tx_sel   = tx_sel_q;

endmodule

// File: tb/tb_s_link_sched.sv
// tb_s_link_sched: directed bench for s_link_sched.
// Default parameters: 4 rounds, unit 0 first, gap 4, timeout 1023.
module tb_s_link_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       S_done_0;
    logic       S_done_1;
    logic       updown_0;
    logic       updown_1;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] round;
    logic       tx_sel;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    s_link_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .S_done_0 (S_done_0),
        .S_done_1 (S_done_1),
        .updown_0 (updown_0),
        .updown_1 (updown_1),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .round    (round),
        .tx_sel   (tx_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every cycle: never both units in send mode; count done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            chk("no_overlap", 32'(updown_0 & updown_1), 32'd0);
            if (done) done_cnt++;
        end
    end

    // Count negedges until the given unit is in send mode (bounded).
    task automatic wait_tx(input logic tx, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (((tx ? updown_1 : updown_0) !== 1'b1) && cyc < 2000);
        if (cyc >= 2000) chk("wait_tx_bound", 32'(cyc), 32'd0);
    endtask

    // From the first XFER cycle, raise rx's done flag 'at' cycles in for one cycle.
    task automatic pulse_done(input logic rx, input int at);
        repeat (at) @(negedge clk);
        if (rx) S_done_1 = 1'b1;
        else    S_done_0 = 1'b1;
        @(negedge clk);
        S_done_0 = 1'b0;
        S_done_1 = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic exp_err);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_up0"}, 32'(updown_0), 32'd0);
        chk({tag, "_up1"}, 32'(updown_1), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int cyc;
        int dc;
        logic t;

        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        S_done_0 = 1'b0;
        S_done_1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst", 1'b0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_txsel", 32'(tx_sel), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: full job, edge 30 cycles into each XFER.
        start = 1'b1;
        for (int r = 0; r < 4; r++) begin
            t = 1'(r);
            wait_tx(t, cyc);
            chk($sformatf("t1_lat%0d", r), 32'(cyc), (r == 0) ? 32'd5 : 32'd4);
            chk($sformatf("t1_round%0d", r), 32'(round), 32'(r));
            chk($sformatf("t1_txsel%0d", r), 32'(tx_sel), 32'(t));
            chk($sformatf("t1_other%0d", r),
                32'(t ? updown_0 : updown_1), 32'd0);
            pulse_done(~t, 30);
            if (r < 3) begin
                chk($sformatf("t1_turn_busy%0d", r), 32'(busy), 32'd1);
                chk($sformatf("t1_turn_up%0d", r),
                    32'(updown_0 | updown_1), 32'd0);
                chk($sformatf("t1_turn_done%0d", r), 32'(done), 32'd0);
            end else begin
                chk("t1_done", 32'(done), 32'd1);
                chk("t1_fin_round", 32'(round), 32'd3);
                chk("t1_fin_up", 32'(updown_0 | updown_1), 32'd0);
            end
        end
        @(negedge clk);
        chk_idle("t1_end", 1'b0);
        chk("t1_end_round", 32'(round), 32'd3);
        @(negedge clk);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Test 2: stale S_done_1 high at entry must not complete round 0.
        S_done_1 = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        wait_tx(1'b0, cyc);
        chk("t2_lat", 32'(cyc), 32'd5);
        repeat (5) @(negedge clk);
        chk("t2_no_early5", 32'(updown_0), 32'd1);
        S_done_1 = 1'b0;
        repeat (14) @(negedge clk);
        chk("t2_no_early19", 32'(updown_0), 32'd1);
        @(negedge clk);
        chk("t2_no_early20", 32'(updown_0), 32'd1);
        S_done_1 = 1'b1;
        @(negedge clk);
        chk("t2_turn_up0", 32'(updown_0), 32'd0);
        chk("t2_turn_busy", 32'(busy), 32'd1);
        chk("t2_turn_round", 32'(round), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        S_done_1 = 1'b0;
        chk_idle("t2_abort", 1'b0);
        repeat (2) @(negedge clk);

        // Test 3: no edge in round 1 -> watchdog error.
        start = 1'b1;
        wait_tx(1'b0, cyc);
        pulse_done(1'b1, 10);
        wait_tx(1'b1, cyc);
        chk("t3_lat_r1", 32'(cyc), 32'd4);
        repeat (1022) @(negedge clk);
        chk("t3_last_xfer", 32'(updown_1), 32'd1);
        chk("t3_no_err_yet", 32'(err), 32'd0);
        @(negedge clk);
        chk_idle("t3_to", 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_err_sticky", 32'(err), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3_err_clr", 32'(err), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);

        // Test 4: continue into round 2, start while busy, then abort.
        wait_tx(1'b0, cyc);
        chk("t4_lat_r0", 32'(cyc), 32'd4);
        pulse_done(1'b1, 3);
        wait_tx(1'b1, cyc);
        pulse_done(1'b0, 3);
        wait_tx(1'b0, cyc);
        chk("t4_round2", 32'(round), 32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_start_up0", 32'(updown_0), 32'd1);
        chk("t4_busy_start_round", 32'(round), 32'd2);
        dc    = done_cnt;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk_idle("t4_abort", 1'b0);
        @(negedge clk);
        chk("t4_stay_idle", 32'(busy), 32'd0);
        chk("t4_no_done", 32'(done_cnt), 32'(dc));

        // Test 5: edge in the same cycle the watchdog expires.
        start = 1'b1;
        wait_tx(1'b0, cyc);
        repeat (1022) @(negedge clk);
        S_done_1 = 1'b1;
        @(negedge clk);
        S_done_1 = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_turn_up", 32'(updown_0 | updown_1), 32'd0);
        wait_tx(1'b1, cyc);
        chk("t5_lat", 32'(cyc), 32'd4);
        chk("t5_round", 32'(round), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("t5_abort", 1'b0);

        // Test 6: asynchronous reset in the middle of TURN.
        start = 1'b1;
        wait_tx(1'b0, cyc);
        pulse_done(1'b1, 5);
        pulse_done(1'b1, 0);
        wait_tx(1'b1, cyc);
        pulse_done(1'b0, 5);
        @(negedge clk);
        chk("t6_in_turn", 32'(busy), 32'd1);
        chk("t6_round", 32'(round), 32'd1);
        chk("t6_txsel", 32'(tx_sel), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("t6_rst", 1'b0);
        chk("t6_rst_round", 32'(round), 32'd0);
        chk("t6_rst_txsel", 32'(tx_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_post_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
